// File: rtl/move_request_gen.sv
// rtl/move_request_gen.sv - debounced button to one-hot move request FSM
// Optional abandon-on-timeout behaviour is compiled in with MOVE_REQ_TIMEOUT_EN.
module move_request_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic        lock,
  input  logic        done,
  output logic [3:0]  direction,
  output logic        busy,
  output logic        move_done,
  output logic [15:0] move_count,
  output logic        err_timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("move_request_gen: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end

  logic [1:0]    state;
  logic [3:0]    sync1, sync2;
  logic [3:0]    deb, deb_q;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    press;
  logic [3:0]    win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_q <= deb;
      // Level flips only after a full run of mismatching cycles; any agreement restarts the run.
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  always_comb begin
    win = 4'b0000;
    if (press[0])      win = 4'b0001;
    else if (press[1]) win = 4'b0010;
    else if (press[2]) win = 4'b0100;
    else if (press[3]) win = 4'b1000;
  end

`ifdef MOVE_REQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          err_q;

  // A done in the final cycle still wins over the timeout.
  assign to_hit = (state == S_ISSUE) && !done && (to_cnt == TO_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == S_ISSUE && !done && !to_hit) to_cnt <= to_cnt + TW'(1);
      else                                      to_cnt <= '0;
      if (to_hit) err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      direction  <= 4'b0000;
      move_done  <= 1'b0;
      move_count <= 16'd0;
    end else begin
      move_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|press && !lock) begin
            state     <= S_ISSUE;
            direction <= win;
          end
        end
        S_ISSUE: begin
          if (done) begin
            state      <= S_RELEASE;
            direction  <= 4'b0000;
            move_done  <= 1'b1;
            move_count <= move_count + 16'd1;
          end
`ifdef MOVE_REQ_TIMEOUT_EN
          else if (to_hit) begin
            state     <= S_IDLE;
            direction <= 4'b0000;
          end
`endif
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_move_request_gen.sv
// tb/tb_move_request_gen.sv - directed self-checking bench for move_request_gen
// Build with or without MOVE_REQ_TIMEOUT_EN; expectations follow the macro.
module tb_move_request_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  btn;
  logic        lock;
  logic        done;
  logic [3:0]  direction;
  logic        busy;
  logic        move_done;
  logic [15:0] move_count;
  logic        err_timeout;

  int tests_run = 0;
  int tests_failed = 0;

  move_request_gen #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .lock(lock), .done(done),
    .direction(direction), .busy(busy), .move_done(move_done),
    .move_count(move_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Advance n clock edges and settle 1 time unit past the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn = 4'b0; lock = 1'b0; done = 1'b0;
    tick(3);
    tests_run++;
    if ({direction, busy, move_done, move_count, err_timeout} !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got dir=%b busy=%b md=%b cnt=%0d err=%b, want all zero",
               direction, busy, move_done, move_count, err_timeout);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_hold_left;
    logic extra;
    btn = 4'b0100;                       // cycle 0
    tick(6);
    tests_run++;
    if (direction !== 4'b0000) begin
      tests_failed++;
      $display("FAIL hold_left_c6: got %b want 0000", direction);
    end
    tick(1);
    tests_run++;
    if (direction !== 4'b0100 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_left_c7: got dir=%b busy=%b want 0100/1", direction, busy);
    end
    tick(1); done = 1'b1;                // cycle 8
    tests_run++;
    if (direction !== 4'b0100) begin
      tests_failed++;
      $display("FAIL hold_left_c8: got %b want 0100", direction);
    end
    tick(1); done = 1'b0;                // cycle 9 : RELEASE
    tests_run++;
    if (direction !== 4'b0000 || move_done !== 1'b1 || move_count !== 16'd1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_left_release: got dir=%b md=%b cnt=%0d busy=%b want 0000/1/1/1",
               direction, move_done, move_count, busy);
    end
    tick(1);
    tests_run++;
    if (move_done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_left_idle: got md=%b busy=%b want 0/0", move_done, busy);
    end
    extra = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (direction !== 4'b0000 || busy !== 1'b0) extra = 1'b1;
    end
    tests_run++;
    if (extra !== 1'b0 || move_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL hold_left_no_repeat: got extra=%b cnt=%0d want 0/1", extra, move_count);
    end
    btn = 4'b0000;
    tick(10);
  endtask

  task automatic test_bounce;
    logic seen;
    seen = 1'b0;
    btn = 4'b0001;
    tick(3);
    btn = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (direction !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0 || move_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL bounce: got seen=%b cnt=%0d want 0/1", seen, move_count);
    end
  endtask

  task automatic test_priority;
    logic seen;
    btn = 4'b1010;
    tick(7);
    tests_run++;
    if (direction !== 4'b0010) begin
      tests_failed++;
      $display("FAIL priority_dir: got %b want 0010", direction);
    end
    tick(1); done = 1'b1;
    tick(1); done = 1'b0;
    tests_run++;
    if (move_done !== 1'b1 || move_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL priority_release: got md=%b cnt=%0d want 1/2", move_done, move_count);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (direction !== 4'b0000) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b0 || move_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL priority_right_discarded: got seen=%b cnt=%0d want 0/2", seen, move_count);
    end
    btn = 4'b0000;
    tick(10);
  endtask

  task automatic test_lock;
    lock = 1'b1;
    btn = 4'b0001;
    tick(10);
    tests_run++;
    if (direction !== 4'b0000 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_suppress: got dir=%b busy=%b want 0000/0", direction, busy);
    end
    lock = 1'b0;
    tick(5);
    tests_run++;
    if (direction !== 4'b0000) begin
      tests_failed++;
      $display("FAIL lock_not_queued: got %b want 0000", direction);
    end
    btn = 4'b0000;
    tick(10);
    btn = 4'b0001;
    tick(7);
    tests_run++;
    if (direction !== 4'b0001) begin
      tests_failed++;
      $display("FAIL lock_repress: got %b want 0001", direction);
    end
    lock = 1'b1;                         // lock rises during ISSUE
    tick(1); done = 1'b1;
    tests_run++;
    if (direction !== 4'b0001) begin
      tests_failed++;
      $display("FAIL lock_no_abort: got %b want 0001", direction);
    end
    tick(1); done = 1'b0;
    tests_run++;
    if (move_done !== 1'b1 || move_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL lock_complete: got md=%b cnt=%0d want 1/3", move_done, move_count);
    end
    lock = 1'b0;
    btn = 4'b0000;
    tick(10);
  endtask

  task automatic test_done_idle;
    done = 1'b1;
    tick(1);
    done = 1'b0;
    tick(1);
    tests_run++;
    if (move_done !== 1'b0 || busy !== 1'b0 || move_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL done_idle: got md=%b busy=%b cnt=%0d want 0/0/3", move_done, busy, move_count);
    end
  endtask

  task automatic test_reset_mid_issue;
    btn = 4'b0100;
    tick(7);
    tests_run++;
    if (direction !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rst_issue_setup: got %b want 0100", direction);
    end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    done = 1'b1;                         // late done after reset
    tests_run++;
    if ({direction, busy, move_done, move_count, err_timeout} !== 23'd0) begin
      tests_failed++;
      $display("FAIL rst_issue_outputs: got dir=%b busy=%b md=%b cnt=%0d err=%b want all zero",
               direction, busy, move_done, move_count, err_timeout);
    end
    tick(1);
    done = 1'b0;
    tests_run++;
    if (move_done !== 1'b0 || busy !== 1'b0 || move_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL rst_late_done: got md=%b busy=%b cnt=%0d want 0/0/0", move_done, busy, move_count);
    end
    tick(5);                             // 6 cycles after reset release
    tests_run++;
    if (direction !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rst_held_early: got %b want 0000", direction);
    end
    tick(1);
    tests_run++;
    if (direction !== 4'b0100) begin
      tests_failed++;
      $display("FAIL rst_held_press: got %b want 0100", direction);
    end
    tick(1); done = 1'b1;
    tick(1); done = 1'b0;
    tests_run++;
    if (move_done !== 1'b1 || move_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL rst_held_complete: got md=%b cnt=%0d want 1/1", move_done, move_count);
    end
    btn = 4'b0000;
    tick(10);
  endtask

  task automatic test_timeout;
    btn = 4'b1000;
    tick(7);
    tests_run++;
    if (direction !== 4'b1000) begin
      tests_failed++;
      $display("FAIL timeout_issue: got %b want 1000", direction);
    end
    tick(15);                            // last ISSUE cycle
    tests_run++;
    if (direction !== 4'b1000 || err_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_c22: got dir=%b err=%b want 1000/0", direction, err_timeout);
    end
    tick(1);
`ifdef MOVE_REQ_TIMEOUT_EN
    tests_run++;
    if (direction !== 4'b0000 || err_timeout !== 1'b1 || busy !== 1'b0 ||
        move_done !== 1'b0 || move_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL timeout_abandon: got dir=%b err=%b busy=%b md=%b cnt=%0d want 0000/1/0/0/1",
               direction, err_timeout, busy, move_done, move_count);
    end
    tick(10);
    tests_run++;
    if (err_timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sticky: got %b want 1", err_timeout);
    end
`else
    tick(20);
    tests_run++;
    if (direction !== 4'b1000 || err_timeout !== 1'b0 || busy !== 1'b1 || move_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL timeout_disabled_hold: got dir=%b err=%b busy=%b cnt=%0d want 1000/0/1/1",
               direction, err_timeout, busy, move_count);
    end
`endif
    btn = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_hold_left();
    test_bounce();
    test_priority();
    test_lock();
    test_done_idle();
    test_reset_mid_issue();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/move_request_gen.md
MOVE_REQUEST_GEN -- requirements
Module: move_request_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles required to accept a button level change.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent in ISSUE waiting for done; used only when the timeout feature is compiled in.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 btn  input  4  raw asynchronous buttons, active-high: bit0 up, bit1 down, bit2 left, bit3 right.
REQ-006 lock  input  1  game locked (won/over); new requests suppressed while high.
REQ-007 done  input  1  move-and-merge completion, sampled high in the cycle after a valid direction is presented.
REQ-008 direction  output  4  one-hot move request to the merge stage (0001 top, 0010 bottom, 0100 left, 1000 right); 0000 = no move.
REQ-009 busy  output  1  high while the FSM is not in IDLE.
REQ-010 move_done  output  1  one-cycle pulse per completed move.
REQ-011 move_count  output  16  completed-move counter.
REQ-012 err_timeout  output  1  sticky flag: a request was abandoned.

Function
REQ-013 Each btn bit SHALL pass a 2-flop synchronizer before any other use.
REQ-014 Per button, a debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle clears that button's counter.
REQ-015 A press event SHALL be a 0->1 transition of a debounced level, valid for exactly one cycle.
REQ-016 Simultaneous press events SHALL resolve by priority up > down > left > right; lower-priority events in that cycle SHALL be discarded.
REQ-017 FSM states SHALL be IDLE, ISSUE, RELEASE.
REQ-018 IDLE -> ISSUE on a press event with lock low; direction SHALL be registered to the winning one-hot code on that transition.
REQ-019 Press events in ISSUE or RELEASE, or in IDLE with lock high, SHALL be discarded, not queued.
REQ-020 In ISSUE, direction SHALL hold constant until done is sampled high; then ISSUE -> RELEASE, direction -> 0000.
REQ-021 In RELEASE, move_done SHALL be high for that single cycle, move_count SHALL increment by 1 (wraps 0xFFFF -> 0x0000), and the next state SHALL be IDLE.
REQ-022 done high in IDLE or RELEASE SHALL be ignored.
REQ-023 lock rising during ISSUE SHALL NOT abort the pending request.
REQ-024 Latency from the first cycle btn is high (held stable) to direction nonzero SHALL be DEBOUNCE_CYCLES + 3 cycles.
REQ-025 A held button SHALL generate exactly one request; a new request requires release then re-press, each debounced.

Reset
REQ-026 With rst_n low at a clock edge: state = IDLE, direction = 0000, busy = 0, move_done = 0, move_count = 0, err_timeout = 0, synchronizers/debounced levels/counters = 0.
REQ-027 Reset asserted mid-ISSUE SHALL drop the request with no move_done and no count increment.
REQ-028 A button held through reset release SHALL produce one press event once debounced.

Configuration
REQ-029 Macro MOVE_REQ_TIMEOUT_EN defined: a counter SHALL run in ISSUE; on reaching TIMEOUT_CYCLES without done, the FSM SHALL go to IDLE, direction -> 0000, set err_timeout (cleared only by reset), with no move_done and no count increment.
REQ-030 MOVE_REQ_TIMEOUT_EN undefined: no timeout counter SHALL exist, ISSUE SHALL wait indefinitely, and err_timeout SHALL be tied 0.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-031 btn=0100 held; done pulsed 1 cycle after direction appears -> direction=0100 at cycle 7, move_done pulse, move_count=1, no second request while held.
REQ-032 btn=0001 high 3 cycles then low (bounce) -> direction stays 0000, move_count=0.
REQ-033 btn=1010 pressed same cycle -> direction=0010 only; the right press is discarded.
REQ-034 lock=1 then btn=0001 press -> no request; lock=0, release and re-press -> direction=0001.
REQ-035 MOVE_REQ_TIMEOUT_EN defined, done never asserted -> direction returns to 0000 after 16 ISSUE cycles, err_timeout=1, move_count unchanged; undefined -> direction held, err_timeout=0.
REQ-036 rst_n low for 1 cycle during ISSUE -> all outputs at reset values next cycle; late done ignored.
